fb_port_arbiter: RTL and testbench
==================================

// Module: fb_port_arbiter
// PURPOSE
//  Shares port A of the 2304x24 frame-buffer RAM (48x48 RGB pixels) between two
//  requesters: r0 = host/UART image loader, r1 = effects/overlay engine. Also holds
//  a fill engine that writes one colour to every pixel. Port B stays with the panel
//  scan logic. Placed between the loaders and the RAM port-A pins.
// PARAMETERS
//  ADDR_W  12    address width
//  DATA_W  24    pixel width, RGB888
//  DEPTH   2304  number of valid pixel addresses (0..DEPTH-1)
// PORTS
//  clk         in   1       single clock; all logic on posedge
//  rst         in   1       asynchronous, active-high reset
//  rN_req      in   1       N=0,1: request; held with cmd until rN_gnt
//  rN_we       in   1       1=write, 0=read
//  rN_addr     in   ADDR_W  pixel address
//  rN_wdata    in   DATA_W  write pixel
//  rN_gnt      out  1       request accepted this cycle (combinational)
//  rN_rvalid   out  1       read data valid, 1-cycle pulse
//  rN_rdata    out  DATA_W  read pixel; valid only while rN_rvalid
//  fill_start  in   1       1-cycle pulse: start a full-frame fill
//  fill_color  in   DATA_W  fill colour, sampled on the accepted fill_start
//  fill_busy   out  1       high while the fill is running
//  fill_done   out  1       1-cycle pulse when the fill completes
//  ram_we      out  1       to RAM we_a
//  ram_re      out  1       to RAM re_a
//  ram_addr    out  ADDR_W  to RAM addr_a
//  ram_wdata   out  DATA_W  to RAM data_in_a
//  ram_rdata   in   DATA_W  from RAM data_out_a
// BEHAVIOUR
//  - Reset: FSM=IDLE, rr pointer=r1 (so r0 wins the first tie), fill counter=0.
//    ram_we, ram_re, ram_addr, ram_wdata, all gnt/rvalid/rdata, fill_busy and
//    fill_done all reset to 0.
//  - ram_* are registered. At most one command per cycle. ram_we and ram_re are
//    never high together.
//  - FSM states: IDLE and FILL.
//  - IDLE: a gnt in cycle T drives ram_* in T+1. The RAM registers the read at the
//    end of T+1. rN_rvalid and rN_rdata=ram_rdata appear in T+2, so read latency is
//    2 cycles from the gnt.
//  - Back-to-back grants are allowed every cycle. Outstanding reads return in grant
//    order (2-stage tag pipeline: valid, owner, oob).
//  - Arbitration: one requester asking gets the gnt. If both ask, the one not
//    granted last gets it; the pointer updates only on a gnt.
//  - Out of range (rN_addr >= DEPTH): the request is still granted.
//    Write -> ram_we stays 0 (dropped). Read -> ram_re stays 0, and rvalid still
//    pulses at T+2 with rdata=0.
//  - fill_start in IDLE -> FILL next cycle; fill_color is latched; no gnt that cycle.
//    Fill beats requests arriving in the same cycle.
//  - FILL: fill_busy=1 and no gnts. One write per cycle to addr 0,1,..,DEPTH-1, so
//    ram_we runs high for DEPTH consecutive cycles.
//  - After the write to DEPTH-1 is issued: the next cycle returns to IDLE, pulses
//    fill_done and drops fill_busy.
//  - Reads granted before the fill still drain their rvalid during the first 2 FILL
//    cycles.
//  - fill_start while in FILL is ignored. Pending requests wait, held, until IDLE.
//  - The counter never wraps: it stops at DEPTH-1.
//  - rst mid-fill: return to IDLE at once, counter=0, no fill_done. Pixels already
//    written stay written.
//  - rst with reads in flight: the tag pipeline clears, so no rvalid is produced.
// STRUCTURE
//  - Shared header fb_defs.vh: FB_ADDR_W, FB_DATA_W, FB_DEPTH, FSM state encodings
//    (ST_IDLE, ST_FILL). Also used by the scan and loader blocks.
//  - Sub-module rr_arbiter2: 2-way round-robin with a last-grant flop and an enable
//    input (low during FILL/fill_start).
//  - Top level holds the FSM, fill counter, output registers and the read tag
//    pipeline.
// TESTING
//  1 r0 write 0x123 <- 0xFF0000, then r0 read 0x123 -> gnt same cycle; ram_we at T+1;
//    r0_rvalid at T+2 of the read with rdata 0xFF0000.
//  2 r0 and r1 both request reads every cycle for 6 cycles -> gnts go r0,r1,r0,r1,r0,r1;
//    each rvalid goes to the correct owner 2 cycles after its gnt.
//  3 fill_start with fill_color=0x00FF00 -> fill_busy for 2304 cycles; ram_addr
//    runs 0..2303; fill_done pulses once; a r1 req held throughout gets its gnt in
//    the cycle after fill_done.
//  4 r1 write at addr 2304 and r1 read at addr 4095 -> both granted; ram_we/ram_re
//    stay 0; the read gives rvalid with rdata=0.
//  5 rst asserted at fill address 1000 -> all outputs 0 asynchronously; IDLE after
//    release; no fill_done; addresses 0..999 hold the fill colour, address 1000 and
//    up keep the old data.
//  6 r0 read granted 1 cycle before fill_start -> its rvalid still arrives; a second
//    fill_start during FILL changes neither the duration nor the colour.

Source files
------------

// File: rtl/fb_port_arbiter_pkg.sv
// fb_port_arbiter_pkg
// Shared frame-buffer definitions for the port-A arbiter: geometry of the
// 48x48 RGB888 frame buffer, the arbiter FSM state encoding and the read
// tag that travels alongside each outstanding read.
package fb_port_arbiter_pkg;

    localparam int FB_ADDR_W = 12;
    localparam int FB_DATA_W = 24;
    localparam int FB_DEPTH  = 2304;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } fb_state_t;

    // valid: a read is in flight; owner: 0 = r0, 1 = r1; oob: address was
    // outside the frame, so the RAM was never read and the answer is zero.
    typedef struct packed {
        logic valid;
        logic owner;
        logic oob;
    } rd_tag_t;

endpackage

// File: rtl/fb_port_arbiter_rr_arbiter2.sv
// fb_port_arbiter_rr_arbiter2
// Two-way round-robin arbiter with a last-grant flop.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   en           arbitration allowed this cycle (low blocks all grants)
//   req0, req1   requests
//   gnt0, gnt1   combinational one-hot grants
module fb_port_arbiter_rr_arbiter2 (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    // 1 = r1 was granted last. Resets to r1 so r0 wins the first tie.
    logic last_r1;

    // A lone requester always wins; on a tie the one not granted last wins.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (en) begin
            if (req0 && (!req1 || last_r1)) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
    end

    // The pointer only moves when a grant is actually given.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_r1 <= 1'b1;
        end else if (gnt0) begin
            last_r1 <= 1'b0;
        end else if (gnt1) begin
            last_r1 <= 1'b1;
        end
    end

endmodule

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter
// Shares frame-buffer RAM port A between the image loader (r0) and the
// effects engine (r1), and contains a fill engine that paints every pixel
// with one colour.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   rN_req/we/addr/wdata (N=0,1)  request command, held until rN_gnt
//   rN_gnt                        combinational accept
//   rN_rvalid, rN_rdata           read return, 2 cycles after the grant
//   fill_start, fill_color        start a full-frame fill with this colour
//   fill_busy, fill_done          fill running / 1-cycle completion pulse
//   ram_we/re/addr/wdata          registered RAM port-A controls
//   ram_rdata                     RAM port-A read data
module fb_port_arbiter
    import fb_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = FB_ADDR_W,
    parameter int DATA_W = FB_DATA_W,
    parameter int DEPTH  = FB_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    input  logic              fill_start,
    input  logic [DATA_W-1:0] fill_color,
    output logic              fill_busy,
    output logic              fill_done,
    output logic              ram_we,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    fb_state_t         state_q, state_d;
    logic [ADDR_W-1:0] fill_cnt;
    logic [DATA_W-1:0] fill_color_q;
    logic              fill_accept, fill_last, fill_done_q;
    logic              arb_en;
    rd_tag_t           tag_s1, tag_s2;
    logic              sel_we, sel_ok;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Grants are blocked during reset, during a fill, in the cycle a fill is
    // accepted, and in the fill_done cycle so the last fill write settles
    // before requesters resume.
    assign arb_en = (state_q == ST_IDLE) && !fill_start && !fill_done_q && !rst;

    fb_port_arbiter_rr_arbiter2 u_arb (
        .clk  (clk),
        .rst  (rst),
        .en   (arb_en),
        .req0 (r0_req),
        .req1 (r1_req),
        .gnt0 (r0_gnt),
        .gnt1 (r1_gnt)
    );

    // Mux the granted command and flag addresses outside the frame.
    always_comb begin
        sel_we    = r0_we;
        sel_addr  = r0_addr;
        sel_wdata = r0_wdata;
        if (r1_gnt) begin
            sel_we    = r1_we;
            sel_addr  = r1_addr;
            sel_wdata = r1_wdata;
        end
        sel_ok = ({1'b0, sel_addr} < DEPTH_EXT);
    end

    // Next-state logic: a fill start in IDLE enters FILL; the cycle that
    // issues the last pixel write returns to IDLE.
    always_comb begin
        state_d     = state_q;
        fill_accept = 1'b0;
        fill_last   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fill_start) begin
                    fill_accept = 1'b1;
                    state_d     = ST_FILL;
                end
            end
            ST_FILL: begin
                if (fill_cnt == LAST_ADDR) begin
                    fill_last = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // RAM port registers, fill counter and the read tag pipeline. The tag
    // pipeline runs independently of the FSM so reads granted just before a
    // fill still return during the first FILL cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_we       <= 1'b0;
            ram_re       <= 1'b0;
            ram_addr     <= '0;
            ram_wdata    <= '0;
            fill_cnt     <= '0;
            fill_color_q <= '0;
            fill_done_q  <= 1'b0;
            tag_s1       <= '0;
            tag_s2       <= '0;
        end else begin
            ram_we      <= 1'b0;
            ram_re      <= 1'b0;
            fill_done_q <= fill_last;
            tag_s1      <= '0;
            tag_s2      <= tag_s1;
            if (fill_accept) begin
                fill_color_q <= fill_color;
                fill_cnt     <= '0;
            end
            if (state_q == ST_FILL) begin
                ram_we    <= 1'b1;
                ram_addr  <= fill_cnt;
                ram_wdata <= fill_color_q;
                if (!fill_last) begin
                    fill_cnt <= fill_cnt + ADDR_W'(1);
                end
            end else if (r0_gnt || r1_gnt) begin
                ram_addr     <= sel_addr;
                ram_wdata    <= sel_wdata;
                ram_we       <= sel_we && sel_ok;
                ram_re       <= !sel_we && sel_ok;
                tag_s1.valid <= !sel_we;
                tag_s1.owner <= r1_gnt;
                tag_s1.oob   <= !sel_ok;
            end
        end
    end

    // Read return: routed by the tag owner; out-of-range reads return zero.
    always_comb begin
        r0_rvalid = tag_s2.valid && !tag_s2.owner;
        r1_rvalid = tag_s2.valid &&  tag_s2.owner;
        r0_rdata  = (r0_rvalid && !tag_s2.oob) ? ram_rdata : '0;
        r1_rdata  = (r1_rvalid && !tag_s2.oob) ? ram_rdata : '0;
    end

    assign fill_busy = (state_q == ST_FILL);
    assign fill_done = fill_done_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb_fb_port_arbiter
// Directed self-checking bench for fb_port_arbiter with a behavioural
// 2304x24 RAM on port A.
module tb_fb_port_arbiter;

    logic        clk, rst;
    logic        r0_req, r0_we, r1_req, r1_we;
    logic [11:0] r0_addr, r1_addr;
    logic [23:0] r0_wdata, r1_wdata;
    logic        r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
    logic [23:0] r0_rdata, r1_rdata;
    logic        fill_start, fill_busy, fill_done;
    logic [23:0] fill_color;
    logic        ram_we, ram_re;
    logic [11:0] ram_addr;
    logic [23:0] ram_wdata, ram_rdata;

    int total = 0;
    int bad   = 0;

    logic [23:0] mem [0:2303];

    fb_port_arbiter dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .fill_start(fill_start), .fill_color(fill_color),
        .fill_busy(fill_busy), .fill_done(fill_done),
        .ram_we(ram_we), .ram_re(ram_re), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural frame-buffer RAM, registered read.
    initial ram_rdata = '0;
    always @(posedge clk) begin
        if (ram_we && ram_addr < 12'd2304) mem[ram_addr] <= ram_wdata;
        if (ram_re && ram_addr < 12'd2304) ram_rdata <= mem[ram_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0;
        r1_req = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0;
        fill_start = 1'b0; fill_color = '0;
        tick();
        tick();
        total++;
        if ({ram_we, ram_re, ram_addr, ram_wdata, r0_rvalid, r1_rvalid, r0_rdata, r1_rdata,
             fill_busy, fill_done} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got we=%b re=%b addr=%h busy=%b done=%b expected all 0",
                     ram_we, ram_re, ram_addr, fill_busy, fill_done);
        end
        total++;
        if (r0_gnt !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_gnt: got %b expected 0", r0_gnt);
        end
        r0_req = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        r0_req = 1'b1; r0_we = 1'b1; r0_addr = 12'h123; r0_wdata = 24'hFF0000;
        #1;
        total++;
        if (r0_gnt !== 1'b1) begin bad++; $display("[TB] FAIL wr_gnt: got %b expected 1", r0_gnt); end
        tick();
        r0_req = 1'b0;
        total++;
        if ({ram_we, ram_re, ram_addr, ram_wdata} !== {1'b1, 1'b0, 12'h123, 24'hFF0000}) begin
            bad++;
            $display("[TB] FAIL wr_ram: got we=%b re=%b addr=%h wdata=%h expected 1 0 123 ff0000",
                     ram_we, ram_re, ram_addr, ram_wdata);
        end
        r0_req = 1'b1; r0_we = 1'b0;
        #1;
        total++;
        if (r0_gnt !== 1'b1) begin bad++; $display("[TB] FAIL rd_gnt: got %b expected 1", r0_gnt); end
        tick();
        r0_req = 1'b0;
        total++;
        if ({ram_we, ram_re, r0_rvalid} !== 3'b010) begin
            bad++;
            $display("[TB] FAIL rd_t1: got we=%b re=%b rvalid=%b expected 0 1 0", ram_we, ram_re, r0_rvalid);
        end
        tick();
        total++;
        if ({r0_rvalid, r1_rvalid, r0_rdata} !== {2'b10, 24'hFF0000}) begin
            bad++;
            $display("[TB] FAIL rd_t2: got rv0=%b rv1=%b rdata=%h expected 1 0 ff0000",
                     r0_rvalid, r1_rvalid, r0_rdata);
        end
        tick();
        total++;
        if (r0_rvalid !== 1'b0) begin bad++; $display("[TB] FAIL rd_t3: got rvalid=%b expected 0", r0_rvalid); end
    endtask

    task automatic test_alternate();
        logic eg0, eg1, ev0, ev1;
        // Seed the two addresses, then reset so r0 wins the first tie.
        r0_req = 1'b1; r0_we = 1'b1; r0_addr = 12'h010; r0_wdata = 24'hA1A1A1;
        tick();
        r0_req = 1'b0;
        r1_req = 1'b1; r1_we = 1'b1; r1_addr = 12'h020; r1_wdata = 24'hB2B2B2;
        tick();
        r1_req = 1'b0;
        tick();
        pulse_reset();
        r0_we = 1'b0; r1_we = 1'b0;
        for (int k = 0; k < 8; k++) begin
            r0_req = (k < 6);
            r1_req = (k < 6);
            #1;
            eg0 = (k < 6) && (k % 2 == 0);
            eg1 = (k < 6) && (k % 2 == 1);
            ev0 = (k >= 2) && ((k - 2) % 2 == 0);
            ev1 = (k >= 2) && ((k - 2) % 2 == 1);
            total++;
            if ({r0_gnt, r1_gnt} !== {eg0, eg1}) begin
                bad++;
                $display("[TB] FAIL alt_gnt k=%0d: got %b%b expected %b%b", k, r0_gnt, r1_gnt, eg0, eg1);
            end
            total++;
            if ({r0_rvalid, r1_rvalid} !== {ev0, ev1}) begin
                bad++;
                $display("[TB] FAIL alt_rvalid k=%0d: got %b%b expected %b%b", k, r0_rvalid, r1_rvalid, ev0, ev1);
            end
            if (ev0) begin
                total++;
                if (r0_rdata !== 24'hA1A1A1) begin
                    bad++; $display("[TB] FAIL alt_rdata0 k=%0d: got %h expected a1a1a1", k, r0_rdata);
                end
            end
            if (ev1) begin
                total++;
                if (r1_rdata !== 24'hB2B2B2) begin
                    bad++; $display("[TB] FAIL alt_rdata1 k=%0d: got %h expected b2b2b2", k, r1_rdata);
                end
            end
            tick();
        end
    endtask

    task automatic test_oob();
        r1_req = 1'b1; r1_we = 1'b1; r1_addr = 12'd2304; r1_wdata = 24'h777777;
        #1;
        total++;
        if (r1_gnt !== 1'b1) begin bad++; $display("[TB] FAIL oob_wr_gnt: got %b expected 1", r1_gnt); end
        tick();
        r1_we = 1'b0; r1_addr = 12'hFFF;
        total++;
        if ({ram_we, ram_re} !== 2'b00) begin
            bad++; $display("[TB] FAIL oob_wr_ram: got we=%b re=%b expected 0 0", ram_we, ram_re);
        end
        #1;
        total++;
        if (r1_gnt !== 1'b1) begin bad++; $display("[TB] FAIL oob_rd_gnt: got %b expected 1", r1_gnt); end
        tick();
        r1_req = 1'b0;
        total++;
        if ({ram_we, ram_re} !== 2'b00) begin
            bad++; $display("[TB] FAIL oob_rd_ram: got we=%b re=%b expected 0 0", ram_we, ram_re);
        end
        tick();
        total++;
        if ({r1_rvalid, r1_rdata} !== {1'b1, 24'h000000}) begin
            bad++; $display("[TB] FAIL oob_rd_ret: got rvalid=%b rdata=%h expected 1 000000", r1_rvalid, r1_rdata);
        end
    endtask

    task automatic test_fill();
        int busy_cnt = 0, we_cnt = 0, wr_err = 0, done_cnt = 0;
        int done_cyc = -1, gnt_cyc = -1;
        logic [11:0] exp_addr = '0;
        fill_color = 24'h00FF00; fill_start = 1'b1;
        r1_req = 1'b1; r1_we = 1'b1; r1_addr = 12'd5; r1_wdata = 24'h123456;
        #1;
        total++;
        if (r1_gnt !== 1'b0) begin bad++; $display("[TB] FAIL fill_beats_req: got gnt=%b expected 0", r1_gnt); end
        for (int c = 1; c < 2400; c++) begin
            tick();
            fill_start = 1'b0;
            if (fill_busy) busy_cnt++;
            if (ram_we) begin
                we_cnt++;
                if (ram_addr !== exp_addr || ram_wdata !== 24'h00FF00) wr_err++;
                exp_addr = exp_addr + 12'd1;
            end
            if (fill_done) begin done_cnt++; done_cyc = c; end
            #1;
            if (r1_gnt) begin gnt_cyc = c; break; end
        end
        tick();
        r1_req = 1'b0;
        tick();
        total++;
        if (busy_cnt != 2304) begin bad++; $display("[TB] FAIL fill_busy_len: got %0d expected 2304", busy_cnt); end
        total++;
        if (we_cnt != 2304 || wr_err != 0) begin
            bad++; $display("[TB] FAIL fill_writes: got %0d writes %0d wrong expected 2304 0", we_cnt, wr_err);
        end
        total++;
        if (done_cnt != 1) begin bad++; $display("[TB] FAIL fill_done_cnt: got %0d expected 1", done_cnt); end
        total++;
        if (gnt_cyc < 0 || gnt_cyc != done_cyc + 1) begin
            bad++; $display("[TB] FAIL fill_gnt_after: got gnt cycle %0d expected %0d", gnt_cyc, done_cyc + 1);
        end
        total++;
        if ({mem[0], mem[2303], mem[5]} !== {24'h00FF00, 24'h00FF00, 24'h123456}) begin
            bad++; $display("[TB] FAIL fill_mem: got %h %h %h expected 00ff00 00ff00 123456", mem[0], mem[2303], mem[5]);
        end
    endtask

    task automatic test_reset_mid_fill();
        logic found = 1'b0;
        fill_color = 24'h0000FF; fill_start = 1'b1;
        for (int c = 0; c < 1200; c++) begin
            tick();
            fill_start = 1'b0;
            if (ram_we && ram_addr == 12'd1000) begin found = 1'b1; break; end
        end
        total++;
        if (!found) begin bad++; $display("[TB] FAIL mid_fill_reach: got no write at 1000 expected one"); end
        rst = 1'b1;
        #1;
        total++;
        if ({ram_we, ram_re, ram_addr, ram_wdata, fill_busy, fill_done, r0_rvalid, r1_rvalid} !== '0) begin
            bad++; $display("[TB] FAIL mid_fill_async: got we=%b addr=%h busy=%b expected 0 000 0",
                            ram_we, ram_addr, fill_busy);
        end
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            total++;
            if ({fill_busy, fill_done} !== 2'b00) begin
                bad++; $display("[TB] FAIL mid_fill_after c=%0d: got busy=%b done=%b expected 0 0", c, fill_busy, fill_done);
            end
        end
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 12'h007;
        #1;
        total++;
        if (r0_gnt !== 1'b1) begin bad++; $display("[TB] FAIL mid_fill_idle: got gnt=%b expected 1", r0_gnt); end
        tick();
        r0_req = 1'b0;
        tick();
        tick();
        total++;
        if ({mem[0], mem[999], mem[1000], mem[2303]} !== {24'h0000FF, 24'h0000FF, 24'h00FF00, 24'h00FF00}) begin
            bad++; $display("[TB] FAIL mid_fill_mem: got %h %h %h %h expected 0000ff 0000ff 00ff00 00ff00",
                            mem[0], mem[999], mem[1000], mem[2303]);
        end
    endtask

    task automatic test_fill_read_drain();
        int busy_cnt = 1, we_cnt = 0, wr_err = 0, done_cnt = 0;
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 12'h010;
        #1;
        total++;
        if (r0_gnt !== 1'b1) begin bad++; $display("[TB] FAIL drain_gnt: got %b expected 1", r0_gnt); end
        tick();
        r0_req = 1'b0; fill_start = 1'b1; fill_color = 24'h111111;
        tick();
        fill_start = 1'b0;
        total++;
        if ({fill_busy, r0_rvalid, r0_rdata} !== {2'b11, 24'h0000FF}) begin
            bad++; $display("[TB] FAIL drain_rvalid: got busy=%b rvalid=%b rdata=%h expected 1 1 0000ff",
                            fill_busy, r0_rvalid, r0_rdata);
        end
        fill_start = 1'b1; fill_color = 24'hABCDEF;
        for (int c = 0; c < 2400; c++) begin
            tick();
            fill_start = 1'b0;
            if (fill_busy) busy_cnt++;
            if (ram_we) begin
                we_cnt++;
                if (ram_wdata !== 24'h111111) wr_err++;
            end
            if (fill_done) begin done_cnt++; break; end
        end
        tick();
        total++;
        if (busy_cnt != 2304 || done_cnt != 1) begin
            bad++; $display("[TB] FAIL refill_len: got busy=%0d done=%0d expected 2304 1", busy_cnt, done_cnt);
        end
        total++;
        if (we_cnt != 2304 || wr_err != 0) begin
            bad++; $display("[TB] FAIL refill_color: got %0d writes %0d wrong expected 2304 0", we_cnt, wr_err);
        end
        total++;
        if ({mem[16], mem[2303]} !== {24'h111111, 24'h111111}) begin
            bad++; $display("[TB] FAIL refill_mem: got %h %h expected 111111 111111", mem[16], mem[2303]);
        end
    endtask

    task automatic test_read_flush();
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 12'h020;
        #1;
        total++;
        if (r1_gnt !== 1'b1) begin bad++; $display("[TB] FAIL flush_gnt: got %b expected 1", r1_gnt); end
        tick();
        r1_req = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            total++;
            if ({r0_rvalid, r1_rvalid} !== 2'b00) begin
                bad++; $display("[TB] FAIL flush_rvalid c=%0d: got %b%b expected 00", c, r0_rvalid, r1_rvalid);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_alternate();
        test_oob();
        test_fill();
        test_reset_mid_fill();
        test_fill_read_drain();
        test_read_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
